// File: rtl/pc_fetch_unit.sv
// PC owner and instruction fetch: req/ack to irom, valid/ready downstream.
// Optional `PC_MISALIGN_CHK_EN` traps misaligned next-PC at retire.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  npc_op,
  input  logic [31:0] ext,
  input  logic [31:0] alu_c,
  input  logic        alu_f,
  output logic        irom_req,
  output logic [31:0] irom_addr,
  input  logic        irom_ack,
  input  logic [31:0] irom_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        fetch_err
`ifdef PC_MISALIGN_CHK_EN
  ,
  output logic        misalign_err
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    ERR
  } state_t;

  localparam logic [1:0] NPC_PC4  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JAL  = 2'd2;
  localparam logic [1:0] NPC_JALR = 2'd3;

  localparam logic [7:0] TO = 8'(FETCH_TIMEOUT);

  state_t      state;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nxt;
  logic [31:0] pc_ext;
  logic [31:0] npc;
  logic        unused_alu_c0;

  assign unused_alu_c0 = alu_c[0];
  assign pc4       = pc + 32'd4;
  assign pc_ext    = pc + ext;
  assign cnt_nxt   = cnt + 8'd1;
  assign irom_addr = pc;

  // Next-PC select, only consumed when the held instruction retires
  always_comb begin
    npc = pc4;
    unique case (1'b1)
      (npc_op == NPC_PC4):  npc = pc4;
      (npc_op == NPC_BR):   npc = alu_f ? pc_ext : pc4;
      (npc_op == NPC_JAL):  npc = pc_ext;
      (npc_op == NPC_JALR): npc = {alu_c[31:1], 1'b0};
    endcase
  end

  // Fetch FSM with registered req/valid/error outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      inst       <= 32'h0;
      inst_valid <= 1'b0;
      irom_req   <= 1'b0;
      fetch_err  <= 1'b0;
      cnt        <= 8'h0;
`ifdef PC_MISALIGN_CHK_EN
      misalign_err <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          irom_req <= 1'b1;
          cnt      <= 8'h0;
          state    <= FETCH;
        end
        FETCH: begin
          if (irom_ack) begin
            inst       <= irom_rdata;
            inst_valid <= 1'b1;
            irom_req   <= 1'b0;
            cnt        <= 8'h0;
            state      <= HOLD;
          end else if (cnt_nxt == TO) begin
            fetch_err <= 1'b1;
            irom_req  <= 1'b0;
            cnt       <= 8'h0;
            state     <= ERR;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        HOLD: begin
          if (inst_valid && inst_ready) begin
`ifdef PC_MISALIGN_CHK_EN
            if (npc[1:0] != 2'b00) begin
              misalign_err <= 1'b1;
              inst_valid   <= 1'b0;
              state        <= ERR;
            end else begin
`else
            begin
`endif
              pc         <= npc;
              inst_valid <= 1'b0;
              irom_req   <= 1'b1;
              state      <= FETCH;
            end
          end
        end
        ERR: begin
          irom_req   <= 1'b0;
          inst_valid <= 1'b0;
        end
        default: state <= ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequencing, next-PC, hold,
// timeout and mid-fetch reset, with a latency-programmable irom.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  npc_op = 2'd0;
  logic [31:0] ext = 32'h0;
  logic [31:0] alu_c = 32'h0;
  logic        alu_f = 1'b0;
  logic        irom_req;
  logic [31:0] irom_addr;
  logic        irom_ack;
  logic [31:0] irom_rdata = 32'h0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        fetch_err;

  logic        mem_ack = 1'b0;
  logic        force_ack = 1'b0;
  bit          mem_en = 1'b1;
  int          lat = 2;
  int          wcnt = 0;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_inst;

  localparam logic [31:0] KEY = 32'hDEAD_0000;

  assign irom_ack = mem_ack | force_ack;

  pc_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .FETCH_TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .npc_op(npc_op),
    .ext(ext),
    .alu_c(alu_c),
    .alu_f(alu_f),
    .irom_req(irom_req),
    .irom_addr(irom_addr),
    .irom_ack(irom_ack),
    .irom_rdata(irom_rdata),
    .inst(inst),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .pc(pc),
    .pc4(pc4),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // irom model: ack after lat waiting cycles, word = addr ^ KEY
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_en && irom_req === 1'b1) begin
      if (wcnt == lat) begin
        mem_ack = 1'b1;
        irom_rdata = irom_addr ^ KEY;
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 30 && inst_valid !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_req();
    for (int i = 0; i < 30 && irom_req !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic accept();
    inst_ready = 1'b1;
    @(posedge clk); #1;
    inst_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    tests++; if (pc !== 32'h0) begin fails++; $display("FAIL rst_pc got %h exp 0", pc); end
    tests++; if (inst !== 32'h0) begin fails++; $display("FAIL rst_inst got %h exp 0", inst); end
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", inst_valid); end
    tests++; if (irom_req !== 1'b0) begin fails++; $display("FAIL rst_req got %b exp 0", irom_req); end
    tests++; if (fetch_err !== 1'b0) begin fails++; $display("FAIL rst_err got %b exp 0", fetch_err); end
    do_reset();
    #1;
    tests++; if (irom_req !== 1'b0) begin fails++; $display("FAIL idle_req got %b exp 0", irom_req); end
  endtask

  task automatic test_seq();
    inst_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_req();
      tests++; if (irom_addr !== 32'(4 * k)) begin fails++; $display("FAIL seq_addr%0d got %h exp %h", k, irom_addr, 4 * k); end
      wait_valid();
      exp_inst = 32'(4 * k) ^ KEY;
      tests++; if (inst_valid !== 1'b1) begin fails++; $display("FAIL seq_valid%0d got %b exp 1", k, inst_valid); end
      tests++; if (inst !== exp_inst) begin fails++; $display("FAIL seq_inst%0d got %h exp %h", k, inst, exp_inst); end
      tests++; if (pc !== 32'(4 * k)) begin fails++; $display("FAIL seq_pc%0d got %h exp %h", k, pc, 4 * k); end
      tests++; if (fetch_err !== 1'b0) begin fails++; $display("FAIL seq_err%0d got %b exp 0", k, fetch_err); end
    end
    inst_ready = 1'b0;
  endtask

  task automatic test_branch();
    npc_op = 2'd0;
    accept();
    tests++; if (pc !== 32'h10) begin fails++; $display("FAIL br_pc10 got %h exp 10", pc); end
    wait_valid();
    npc_op = 2'd1; ext = 32'hFFFF_FFF0; alu_f = 1'b1;
    accept();
    tests++; if (irom_addr !== 32'h0) begin fails++; $display("FAIL br_taken got %h exp 0", irom_addr); end
    wait_valid();
    npc_op = 2'd2; ext = 32'h10;
    accept();
    wait_valid();
    npc_op = 2'd1; ext = 32'hFFFF_FFF0; alu_f = 1'b0;
    accept();
    tests++; if (irom_addr !== 32'h14) begin fails++; $display("FAIL br_not got %h exp 14", irom_addr); end
    wait_valid();
  endtask

  task automatic test_jump();
    npc_op = 2'd3; alu_c = 32'h0000_1235;
    accept();
    tests++; if (pc !== 32'h1234) begin fails++; $display("FAIL jalr got %h exp 1234", pc); end
    wait_valid();
    alu_c = 32'h21;
    accept();
    wait_valid();
    tests++; if (pc !== 32'h20) begin fails++; $display("FAIL jalr20 got %h exp 20", pc); end
    tests++; if (pc4 !== 32'h24) begin fails++; $display("FAIL pc4 got %h exp 24", pc4); end
    npc_op = 2'd2; ext = 32'h100;
    accept();
    tests++; if (pc !== 32'h120) begin fails++; $display("FAIL jal got %h exp 120", pc); end
    wait_valid();
  endtask

  task automatic test_hold();
    exp_inst = 32'h120 ^ KEY;
    repeat (5) begin
      @(posedge clk); #1;
      tests++; if (inst !== exp_inst) begin fails++; $display("FAIL hold_inst got %h exp %h", inst, exp_inst); end
      tests++; if (pc !== 32'h120) begin fails++; $display("FAIL hold_pc got %h exp 120", pc); end
      tests++; if (inst_valid !== 1'b1) begin fails++; $display("FAIL hold_valid got %b exp 1", inst_valid); end
      tests++; if (irom_req !== 1'b0) begin fails++; $display("FAIL hold_req got %b exp 0", irom_req); end
    end
    npc_op = 2'd0;
    accept();
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL acc_valid got %b exp 0", inst_valid); end
    wait_valid();
    tests++; if (pc !== 32'h124) begin fails++; $display("FAIL acc_once got %h exp 124", pc); end
    exp_inst = 32'h124 ^ KEY;
    tests++; if (inst !== exp_inst) begin fails++; $display("FAIL acc_inst got %h exp %h", inst, exp_inst); end
  endtask

  task automatic test_wrap();
    npc_op = 2'd3; alu_c = 32'hFFFF_FFFC;
    accept();
    wait_valid();
    tests++; if (pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_pc got %h exp fffffffc", pc); end
    tests++; if (pc4 !== 32'h0) begin fails++; $display("FAIL wrap_pc4 got %h exp 0", pc4); end
    npc_op = 2'd0;
    accept();
    tests++; if (pc !== 32'h0) begin fails++; $display("FAIL wrap_npc got %h exp 0", pc); end
    wait_valid();
  endtask

  task automatic test_timeout();
    mem_en = 1'b0;
    accept();
    repeat (3) begin @(posedge clk); #1; end
    tests++; if (irom_req !== 1'b1) begin fails++; $display("FAIL to_req3 got %b exp 1", irom_req); end
    tests++; if (fetch_err !== 1'b0) begin fails++; $display("FAIL to_err3 got %b exp 0", fetch_err); end
    @(posedge clk); #1;
    tests++; if (fetch_err !== 1'b1) begin fails++; $display("FAIL to_err4 got %b exp 1", fetch_err); end
    tests++; if (irom_req !== 1'b0) begin fails++; $display("FAIL to_req4 got %b exp 0", irom_req); end
    mem_en = 1'b1;
    inst_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    inst_ready = 1'b0;
    tests++; if (fetch_err !== 1'b1) begin fails++; $display("FAIL err_sticky got %b exp 1", fetch_err); end
    tests++; if (irom_req !== 1'b0) begin fails++; $display("FAIL err_req got %b exp 0", irom_req); end
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL err_valid got %b exp 0", inst_valid); end
    lat = 3;
    do_reset();
    wait_valid();
    tests++; if (inst_valid !== 1'b1) begin fails++; $display("FAIL ack4_valid got %b exp 1", inst_valid); end
    tests++; if (fetch_err !== 1'b0) begin fails++; $display("FAIL ack4_err got %b exp 0", fetch_err); end
    tests++; if (inst !== KEY) begin fails++; $display("FAIL ack4_inst got %h exp %h", inst, KEY); end
  endtask

  task automatic test_reset_mid();
    npc_op = 2'd0;
    accept();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    tests++; if (pc !== 32'h0) begin fails++; $display("FAIL mid_pc got %h exp 0", pc); end
    tests++; if (irom_req !== 1'b0) begin fails++; $display("FAIL mid_req got %b exp 0", irom_req); end
    force_ack = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL mid_valid got %b exp 0", inst_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    force_ack = 1'b0;
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL late_ack got %b exp 0", inst_valid); end
    tests++; if (irom_req !== 1'b1) begin fails++; $display("FAIL refetch_req got %b exp 1", irom_req); end
    tests++; if (irom_addr !== 32'h0) begin fails++; $display("FAIL refetch_addr got %h exp 0", irom_addr); end
    wait_valid();
    tests++; if (pc !== 32'h0) begin fails++; $display("FAIL refetch_pc got %h exp 0", pc); end
    tests++; if (inst !== KEY) begin fails++; $display("FAIL refetch_inst got %h exp %h", inst, KEY); end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_branch();
    test_jump();
    test_hold();
    test_wrap();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule
